// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types for the memory-access stage that sits after execute.
//   Inst          : the fields of an executed instruction this stage consumes
//   MemState      : state encoding of the memory-access controller
//   MEM_ALIGN_MASK: low address bits that must be zero for a word access
//   is_misaligned : helper applying MEM_ALIGN_MASK to the low address bits
// ---------------------------------------------------------------------------
package mem_access_pkg;

   // Instruction fields seen by the memory stage. memwrite sits next to
   // memread so a store can be told apart from a load without decoding.
   typedef struct packed {
      logic [5:0] rd;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
   } Inst;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } MemState;

   localparam logic [1:0] MEM_ALIGN_MASK = 2'b11;

   // Only the two low address bits matter for word alignment, so only those
   // are passed in.
   function automatic logic is_misaligned(input logic [1:0] addr_lo);
      return (addr_lo & MEM_ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_timeout.sv
// ---------------------------------------------------------------------------
// mem_timeout
// Wait counter with clear/increment controls. Kept free of any memory-stage
// knowledge so it can be reused for other request/response ports.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the counter (has priority over inc)
//   inc       : advance the counter by one this cycle
//   expired   : high in the cycle whose increment brings the count to LIMIT,
//               i.e. the LIMIT-th consecutive incremented cycle after clear
// ---------------------------------------------------------------------------
module mem_timeout #(
   parameter int CNT_W = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] count;

   // The count itself; clear wins over inc so a fresh request always starts
   // timing from zero even if the caller happens to assert both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // Flag the increment that reaches LIMIT so the owner can react in the
   // same cycle instead of one cycle late.
   always_comb begin
      expired = inc && (count == LAST);
   end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Memory-access stage following execute. Performs at most one word load or
// store per instruction over a valid/ready data-memory port and presents a
// registered writeback bundle with a one-cycle fin pulse.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : one-cycle start pulse; inst/aluresult/result/rdata1
//                     are only valid in that cycle
//   inst            : executed instruction (rd, regwrite, memread, memwrite)
//   aluresult       : effective byte address
//   result          : ALU/FPU value for non-memory instructions
//   rdata1          : store data
//   fin             : one-cycle done pulse
//   busy            : high from accepted enable up to and including fin
//   err             : sticky misalignment / timeout flag, cleared by rst
//   rd_out, regwrite_out, wb_data : writeback bundle (regwrite_out only
//                     asserted together with fin)
//   mem_req/ready/we/addr/wdata   : request channel to data memory
//   mem_rvalid/rdata              : response channel from data memory
// ---------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LAT_MAX = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  Inst               inst,
   input  logic [31:0]       aluresult,
   input  logic [31:0]       result,
   input  logic [31:0]       rdata1,
   output logic              fin,
   output logic              busy,
   output logic              err,
   output logic [5:0]        rd_out,
   output logic              regwrite_out,
   output logic [31:0]       wb_data,
   output logic              mem_req,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   MemState state;
   MemState next_state;

   Inst  inst_q;
   logic wb_en_q;

   logic accept;
   logic mem_op;
   logic misaligned;
   logic cnt_clear;
   logic cnt_inc;
   logic timeout_hit;
   logic resp_hit;

   mem_timeout #(
      .CNT_W (CNT_W),
      .LIMIT (LAT_MAX)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .inc     (cnt_inc),
      .expired (timeout_hit)
   );

   // State register. Reset drops straight back to IDLE, which also kills any
   // outstanding request since mem_req and fin are decoded from the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. Enable is only honoured in IDLE, which
   // makes enable-while-busy and enable-in-DONE silently ignored. A response
   // beats a timeout if both land in the same cycle.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      cnt_clear  = 1'b0;
      cnt_inc    = 1'b0;
      resp_hit   = 1'b0;
      mem_op     = inst.memread | inst.memwrite;
      misaligned = is_misaligned(aluresult[1:0]);

      case (state)
         IDLE: begin
            if (enable) begin
               accept = 1'b1;
               if (mem_op && !misaligned) begin
                  next_state = REQ;
               end else begin
                  next_state = DONE;
               end
            end
         end
         REQ: begin
            if (mem_ready) begin
               cnt_clear  = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            cnt_inc = 1'b1;
            if (mem_rvalid) begin
               resp_hit   = 1'b1;
               next_state = DONE;
            end else if (timeout_hit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Status and request strobes come straight from the state so they clear
   // the instant reset is asserted.
   always_comb begin
      fin          = (state == DONE);
      busy         = (state != IDLE);
      mem_req      = (state == REQ);
      regwrite_out = (state == DONE) && wb_en_q;
   end

   // Datapath registers. The request fields are captured at accept and held
   // untouched through any ready stall. The writeback bundle is only written
   // on the transition into DONE so it keeps its old value between fins;
   // stores, misaligned accesses and timeouts leave wb_data alone and never
   // enable the register-file write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q    <= '0;
         wb_en_q   <= 1'b0;
         err       <= 1'b0;
         rd_out    <= '0;
         wb_data   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (accept) begin
            inst_q <= inst;
            if (!mem_op) begin
               rd_out  <= inst.rd;
               wb_data <= result;
               wb_en_q <= inst.regwrite;
            end else if (misaligned) begin
               rd_out  <= inst.rd;
               wb_en_q <= 1'b0;
               err     <= 1'b1;
            end else begin
               mem_we    <= inst.memwrite;
               mem_addr  <= {aluresult[ADDR_W-1:2], 2'b00};
               mem_wdata <= rdata1;
            end
         end

         if (resp_hit) begin
            rd_out  <= inst_q.rd;
            wb_en_q <= inst_q.regwrite & ~inst_q.memwrite;
            if (inst_q.memread && !inst_q.memwrite) begin
               wb_data <= mem_rdata;
            end
         end else if ((state == WAIT) && timeout_hit) begin
            rd_out  <= inst_q.rd;
            wb_en_q <= 1'b0;
            err     <= 1'b1;
         end
      end
   end

endmodule
